// File: rtl/aemb_wb_arbiter.sv
// Two-master (iwb/dwb) to one-slave WISHBONE arbiter with alternating tie priority.
// Optional grant timeout with sticky error flag when ARB_TIMEOUT_EN is defined.
module aemb_wb_arbiter #(
  parameter int AW  = 32,
  parameter int TMO = 255
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic          iwb_stb_i,
  input  logic [AW-3:0] iwb_adr_i,
  output logic [31:0]   iwb_dat_o,
  output logic          iwb_ack_o,
  input  logic          dwb_stb_i,
  input  logic          dwb_wre_i,
  input  logic [3:0]    dwb_sel_i,
  input  logic [AW-3:0] dwb_adr_i,
  input  logic [31:0]   dwb_dat_i,
  output logic [31:0]   dwb_dat_o,
  output logic          dwb_ack_o,
  output logic          mem_stb_o,
  output logic          mem_wre_o,
  output logic [3:0]    mem_sel_o,
  output logic [AW-3:0] mem_adr_o,
  output logic [31:0]   mem_dat_o,
  input  logic [31:0]   mem_dat_i,
  input  logic          mem_ack_i,
  output logic          arb_err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic        w_syn;
  logic        w_ack;
  logic [31:0] w_rdat;

  if (TMO < 1 || TMO > 255) begin : g_bad_tmo
    $error("aemb_wb_arbiter: TMO must be in 1..255");
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_err;

  // Counter is held at zero in IDLE so it is already clear on grant entry.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == IDLE || mem_ack_i) r_cnt <= '0;
      else                              r_cnt <= r_cnt + 8'd1;
      if (w_syn) r_err <= 1'b1;
    end
  end

  assign w_syn     = (r_state != IDLE) && !mem_ack_i && (r_cnt == 8'(TMO));
  assign arb_err_o = r_err;
  assign w_rdat    = w_syn ? 32'hDEAD_DEAD : mem_dat_i;
`else
  assign w_syn     = 1'b0;
  assign arb_err_o = 1'b0;
  assign w_rdat    = mem_dat_i;
`endif

  assign w_ack = mem_ack_i | w_syn;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state != IDLE && w_ack) r_last <= (r_state == GNT_D);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (iwb_stb_i && dwb_stb_i) w_next = r_last ? GNT_I : GNT_D;
        else if (dwb_stb_i)         w_next = GNT_D;
        else if (iwb_stb_i)         w_next = GNT_I;
      end
      GNT_I:   if (w_ack || !iwb_stb_i) w_next = IDLE;
      GNT_D:   if (w_ack || !dwb_stb_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_stb_o = 1'b0;
    mem_wre_o = 1'b0;
    mem_sel_o = '0;
    mem_adr_o = '0;
    mem_dat_o = '0;
    case (r_state)
      GNT_I: begin
        mem_stb_o = iwb_stb_i;
        mem_sel_o = '1;
        mem_adr_o = iwb_adr_i;
      end
      GNT_D: begin
        mem_stb_o = dwb_stb_i;
        mem_wre_o = dwb_wre_i;
        mem_sel_o = dwb_sel_i;
        mem_adr_o = dwb_adr_i;
        mem_dat_o = dwb_dat_i;
      end
      default: ;
    endcase
  end

  assign iwb_ack_o = (r_state == GNT_I) & w_ack;
  assign dwb_ack_o = (r_state == GNT_D) & w_ack;
  assign iwb_dat_o = w_rdat;
  assign dwb_dat_o = w_rdat;

endmodule
